// File: rtl/vedic_mult_seq.sv
// Sequential signed/unsigned multiplier built from four HxH Urdhva-Tiryakbhyam partial products.
// Latency 6 edges from input transfer to out_valid; result holds in DONE until out_ready.
module vedic_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       k;
  logic             fix_ph;
  logic             sign;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [W2-1:0]    acc;

  logic             take;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [H-1:0]     pp_x;
  logic [H-1:0]     pp_y;
  logic [W2-1:0]    pp_ext;
  logic [W2-1:0]    pp_sh;

  // Crosswise column sums: each output column adds every x[i]&y[j-i] plus the carry from below.
  function automatic logic [2*H-1:0] vedic_hxh(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-1:0] r;
    logic [2*H-1:0] col;
    logic [H-1:0]   ys;
    r   = '0;
    col = '0;
    for (int j = 0; j < 2*H; j++) begin
      for (int i = 0; i < H; i++) begin
        ys  = (j >= i && j - i < H) ? (y >> (j - i)) : '0;
        col = col + {{(2*H-1){1'b0}}, x[i] & ys[0]};
      end
      r[j] = col[0];
      col  = col >> 1;
    end
    return r;
  endfunction

  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign take      = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_comb begin
    pp_x = ma[H-1:0];
    pp_y = mb[H-1:0];
    case (k)
      2'd1:    begin pp_x = ma[H-1:0];     pp_y = mb[WIDTH-1:H]; end
      2'd2:    begin pp_x = ma[WIDTH-1:H]; pp_y = mb[H-1:0];     end
      2'd3:    begin pp_x = ma[WIDTH-1:H]; pp_y = mb[WIDTH-1:H]; end
      default: begin pp_x = ma[H-1:0];     pp_y = mb[H-1:0];     end
    endcase
    pp_ext = {{(W2-2*H){1'b0}}, vedic_hxh(pp_x, pp_y)};
    case (k)
      2'd1, 2'd2: pp_sh = pp_ext << H;
      2'd3:       pp_sh = pp_ext << WIDTH;
      default:    pp_sh = pp_ext;
    endcase
  end

  // FIX spends one cycle negating in place and one registering into c, keeping the wide negate off the output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k      <= 2'd0;
      fix_ph <= 1'b0;
      sign   <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      c      <= '0;
    end else if (take) begin
      state  <= S_MUL;
      k      <= 2'd0;
      fix_ph <= 1'b0;
      sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      ma     <= a_mag;
      mb     <= b_mag;
      acc    <= '0;
    end else begin
      case (state)
        S_MUL: begin
          acc <= acc + pp_sh;
          k   <= k + 2'd1;
          if (k == 2'd3) state <= S_FIX;
        end
        S_FIX: begin
          if (!fix_ph) begin
            if (sign) acc <= ~acc + 1'b1;
            fix_ph <= 1'b1;
          end else begin
            c      <= acc;
            fix_ph <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vedic_mult_seq.md
VEDIC_MULT_SEQ -- requirements
Module: vedic_mult_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, the operand width, which SHALL be even and >= 4; H = WIDTH/2.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  a, b and is_signed are valid.
REQ-005 in_ready  output  1  the block can accept an operand pair this cycle.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 out_valid  output  1  c holds a completed product.
REQ-010 out_ready  input  1  the consumer accepts c this cycle.
REQ-011 c  output  2*WIDTH  product, two's-complement when the captured is_signed = 1.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready on a rising edge; a, b and is_signed SHALL be captured at that edge.
REQ-014 If is_signed = 1, the captured operands SHALL be converted to magnitudes and sign = a[MSB] ^ b[MSB] SHALL be recorded; otherwise sign = 0.
REQ-015 States SHALL be IDLE, MUL, FIX and DONE.
REQ-016 IDLE -> MUL on an input transfer.
REQ-017 MUL SHALL last exactly 4 cycles, with step index k = 0..3.
REQ-018 In MUL step k, one HxH vedic (Urdhva-Tiryakbhyam) partial product SHALL be formed and added into the 2*WIDTH accumulator:
- k=0: aL*bL, shift 0
- k=1: aL*bH, shift H
- k=2: aH*bL, shift H
- k=3: aH*bH, shift 2H
REQ-019 The accumulator SHALL be cleared on the input transfer.
REQ-020 MUL -> FIX after step 3; in FIX, the accumulator SHALL be two's-complement negated if sign = 1, else passed unchanged, and written to c.
REQ-021 FIX -> DONE unconditionally; out_valid SHALL be high exactly while in DONE.
REQ-022 Latency: out_valid SHALL rise at the 6th rising edge after the input transfer edge (4 MUL + 1 FIX + 1).
REQ-023 In DONE, c and out_valid SHALL hold stable until out_valid && out_ready (output transfer).
REQ-024 in_ready SHALL be high in IDLE, and in DONE when out_ready = 1; it SHALL be low in MUL and FIX.
REQ-025 On an output transfer with no simultaneous input transfer, the state SHALL go DONE -> IDLE.
REQ-026 On a simultaneous input and output transfer in DONE, the state SHALL go DONE -> MUL with the new operands, with no idle cycle; throughput is therefore one product per 6 cycles.
REQ-027 c SHALL retain the last product after an output transfer, until the next FIX overwrites it.
REQ-028 Edge cases SHALL be exact with no saturation:
- most-negative x most-negative (signed) SHALL yield +2^(2*WIDTH-2)
- zero operands with sign = 1 SHALL yield 0
REQ-029 in_valid while not in_ready SHALL be ignored, with no capture and no state change.

Reset
REQ-030 rst_n low SHALL immediately force state = IDLE, k = 0, accumulator = 0, c = 0, out_valid = 0 and busy = 0, independent of clk; in_ready SHALL then be 1.
REQ-031 Reset asserted during MUL, FIX or DONE SHALL abort the operation; no out_valid SHALL follow after release until a new input transfer.
REQ-032 After rst_n deasserts, the first input transfer SHALL be possible on the first rising edge.

Verification
REQ-033 Unsigned, WIDTH=16, out_ready=1, each pair sent back-to-back:
- 12*12 -> c = 144
- 15*13 -> 195
- 24*2 -> 48
- 200*21 -> 4200
- 36*48 -> 1728
- each result SHALL appear 6 edges after its transfer
REQ-034 Extremes, WIDTH=16:
- unsigned 65535*65535 -> 32'hFFFE0001
- signed -3*5 -> 32'hFFFFFFF1
- signed -32768*-32768 -> 32'h40000000
- 0*-7 signed -> 0
REQ-035 Backpressure: hold out_ready=0 for 10 cycles after out_valid.
- c and out_valid SHALL stay stable and in_ready SHALL stay low
- out_ready=1 together with in_valid=1 -> next transfer accepted that edge and busy stays high
REQ-036 Reset mid-op: pulse rst_n low during MUL step 2, asynchronously between clock edges.
- outputs SHALL be zero immediately
- no out_valid SHALL appear for 20 cycles with in_valid=0
REQ-037 Parameter sweep: WIDTH = 4, 8 and 32, 1000 random operand pairs each, both modes; every c SHALL match a reference a*b model.
